// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives an external round-key datapath and keeps rk[0..NR] for readback.
// Optional macro KEY_SCHED_CTRL_STREAM_EN adds a valid/ready stream of the keys in decryption order.
`timescale 1ns/1ps
module key_sched_ctrl #(
  parameter int NR     = 10,
  parameter bit RD_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic [127:0] dp_temp_key,
  output logic [31:0]  dp_rcon,
  input  logic [127:0] dp_ko,
`ifdef KEY_SCHED_CTRL_STREAM_EN
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [127:0] ks_key,
  output logic [3:0]   ks_idx,
`endif
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t       state;
  logic [127:0] key_reg;
  logic [3:0]   r;
  logic [127:0] rk [0:NR];
  logic [127:0] rd_sel;
  logic         start_acc;

  function automatic logic [7:0] rc_of(input logic [3:0] n);
    case (n)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Indices beyond NR have no storage behind them and read as zero.
  function automatic logic [127:0] rk_at(input logic [3:0] idx);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i <= NR; i++) begin
      if (idx == 4'(i)) v = rk[i];
    end
    return v;
  endfunction

  assign start_acc = start && ((state == IDLE) || (state == DONE));
  assign busy      = (state == LOAD) || (state == EXPAND);

  // dp_temp_key is loaded with whatever was just written to rk, so the datapath sees a flop, not a mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_reg     <= '0;
      r           <= '0;
      done        <= 1'b0;
      keys_valid  <= 1'b0;
      dp_temp_key <= '0;
      dp_rcon     <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_reg    <= key_in;
            keys_valid <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          rk[0]       <= key_reg;
          dp_temp_key <= key_reg;
          r           <= 4'd1;
          dp_rcon     <= {rc_of(4'd1), 24'h0};
          state       <= EXPAND;
        end
        EXPAND: begin
          for (int i = 1; i <= NR; i++) begin
            if (r == 4'(i)) rk[i] <= dp_ko;
          end
          dp_temp_key <= dp_ko;
          r           <= r + 4'd1;
          if (r == 4'(NR)) begin
            state      <= DONE;
            done       <= 1'b1;
            keys_valid <= 1'b1;
            dp_rcon    <= '0;
          end else begin
            dp_rcon <= {rc_of(r + 4'd1), 24'h0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb rd_sel = rk_at(rd_idx);

  generate
    if (RD_REG) begin : g_rd_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_key <= '0;
        else        rd_key <= rd_sel;
      end
    end else begin : g_rd_comb
      always_comb rd_key = rd_sel;
    end
  endgenerate

`ifdef KEY_SCHED_CTRL_STREAM_EN
  // A new accepted start wins over everything so a stale stream never leaks into a new expansion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_valid <= 1'b0;
      ks_idx   <= '0;
      ks_key   <= '0;
    end else if (start_acc) begin
      ks_valid <= 1'b0;
    end else if (done) begin
      ks_valid <= 1'b1;
      ks_idx   <= 4'(NR);
      ks_key   <= rk[NR];
    end else if (ks_valid && ks_ready) begin
      if (ks_idx == 4'd0) begin
        ks_valid <= 1'b0;
      end else begin
        ks_idx <= ks_idx - 4'd1;
        ks_key <= rk_at(ks_idx - 4'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl with a behavioural AES-128 key-expansion datapath beside it.
`timescale 1ns/1ps
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid;
  logic [127:0] dp_temp_key, dp_ko, rd_key;
  logic [31:0]  dp_rcon;
  logic [3:0]   rd_idx;
`ifdef KEY_SCHED_CTRL_STREAM_EN
  logic         ks_valid, ks_ready;
  logic [127:0] ks_key;
  logic [3:0]   ks_idx;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0]   sbox [0:255];
  logic [7:0]   rc_tab [1:10];
  logic [127:0] fips_rk [0:10];
  logic [127:0] model_rk [0:10];

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [0:12];

  always #5 clk = ~clk;

  key_sched_ctrl #(.NR(10), .RD_REG(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .key_in(key_in),
    .busy(busy),
    .done(done),
    .keys_valid(keys_valid),
    .dp_temp_key(dp_temp_key),
    .dp_rcon(dp_rcon),
    .dp_ko(dp_ko),
`ifdef KEY_SCHED_CTRL_STREAM_EN
    .ks_valid(ks_valid),
    .ks_ready(ks_ready),
    .ks_key(ks_key),
    .ks_idx(ks_idx),
`endif
    .rd_idx(rd_idx),
    .rd_key(rd_key)
  );

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // One AES-128 expansion round: the external datapath this controller sequences.
  function automatic logic [127:0] ks_step(input logic [127:0] tk, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    {w0, w1, w2, w3} = tk;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ rc;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb dp_ko = ks_step(dp_temp_key, dp_rcon);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic buildModel(input logic [127:0] key);
    model_rk[0] = key;
    for (int i = 1; i <= 10; i++) model_rk[i] = ks_step(model_rk[i-1], {rc_tab[i], 24'h0});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts an expansion (caller holds rd_idx = 0) and follows it cycle by cycle up to the done pulse.
  task automatic applyStimulus(input logic [127:0] key, input int inject_at, input logic [127:0] pre_rk0);
    int busy_cnt;
    int done_idx;
    busy_cnt = 0;
    done_idx = -1;
    start    = 1'b1;
    key_in   = key;
    step();
    start  = 1'b0;
    key_in = '1;
    checkOutput("kv_clear_at_start", 128'(keys_valid), 128'(1'b0));
    if (busy) busy_cnt++;
    for (int k = 1; k <= 30; k++) begin
      start = ((k - 1) == inject_at);
      step();
      if (busy) busy_cnt++;
      if (k == 1) checkOutput("read_before_write", rd_key, pre_rk0);
      if (k == 2) checkOutput("read_rk0_new", rd_key, key);
      if (k <= 10) begin
        checkOutput($sformatf("rcon_r%0d", k), 128'(dp_rcon), 128'({rc_tab[k], 24'h0}));
        checkOutput($sformatf("temp_key_r%0d", k), dp_temp_key, model_rk[k-1]);
      end
      if (done) begin
        done_idx = k;
        break;
      end
    end
    start = 1'b0;
    checkOutput("done_latency", 128'(done_idx), 128'(11));
    checkOutput("busy_cycles", 128'(busy_cnt), 128'(11));
    checkOutput("busy_at_done", 128'(busy), 128'(1'b0));
    checkOutput("kv_at_done", 128'(keys_valid), 128'(1'b1));
    checkOutput("rcon_at_done", 128'(dp_rcon), 128'(0));
    checkOutput("temp_key_at_done", dp_temp_key, model_rk[10]);
    step();
    checkOutput("done_one_cycle", 128'(done), 128'(1'b0));
    checkOutput("kv_holds", 128'(keys_valid), 128'(1'b1));
  endtask

  initial begin
    int cnt_done, cnt_busy;
    sbox = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    fips_rk = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    for (int i = 0; i <= 10; i++) vecs[i] = '{idx: 4'(i), exp: fips_rk[i]};
    vecs[11] = '{idx: 4'd11, exp: 128'h0};
    vecs[12] = '{idx: 4'd12, exp: 128'h0};

    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rd_idx = 4'd0;
`ifdef KEY_SCHED_CTRL_STREAM_EN
    ks_ready = 1'b0;
`endif
    repeat (3) step();
    checkOutput("rst_busy", 128'(busy), 128'(1'b0));
    checkOutput("rst_done", 128'(done), 128'(1'b0));
    checkOutput("rst_kv", 128'(keys_valid), 128'(1'b0));
    checkOutput("rst_rd_key", rd_key, 128'h0);
    checkOutput("rst_rcon", 128'(dp_rcon), 128'h0);
    checkOutput("rst_temp_key", dp_temp_key, 128'h0);
`ifdef KEY_SCHED_CTRL_STREAM_EN
    checkOutput("rst_ks_valid", 128'(ks_valid), 128'h0);
    checkOutput("rst_ks_idx", 128'(ks_idx), 128'h0);
    checkOutput("rst_ks_key", ks_key, 128'h0);
`endif
    rst_n = 1'b1;
    step();
    checkOutput("idle_not_busy", 128'(busy), 128'(1'b0));

    $display("[TB] expansion of the FIPS-197 key");
    buildModel(fips_rk[0]);
    applyStimulus(fips_rk[0], -1, 128'h0);
    for (int i = 0; i <= 12; i++) begin
      rd_idx = vecs[i].idx;
      step();
      checkOutput($sformatf("read_rk%0d", vecs[i].idx), rd_key, vecs[i].exp);
    end

`ifdef KEY_SCHED_CTRL_STREAM_EN
    begin
      int          exp_idx, ntr;
      logic        stalled, rdy;
      logic [3:0]  p_idx;
      logic [127:0] p_key;
      exp_idx = 10;
      ntr     = 0;
      stalled = 1'b0;
      p_idx   = '0;
      p_key   = '0;
      $display("[TB] streaming keys with random ready");
      checkOutput("ks_valid_after_done", 128'(ks_valid), 128'(1'b1));
      checkOutput("ks_first_idx", 128'(ks_idx), 128'(10));
      for (int c = 0; c < 400 && ntr < 11; c++) begin
        if (stalled) begin
          checkOutput("ks_hold_idx", 128'(ks_idx), 128'(p_idx));
          checkOutput("ks_hold_key", ks_key, p_key);
        end
        rdy      = 1'($urandom_range(0, 1));
        ks_ready = rdy;
        if (ks_valid && rdy) begin
          checkOutput($sformatf("ks_idx_xfer%0d", ntr), 128'(ks_idx), 128'(exp_idx));
          checkOutput($sformatf("ks_key_xfer%0d", ntr), ks_key, fips_rk[exp_idx]);
          exp_idx--;
          ntr++;
        end
        stalled = ks_valid && !rdy;
        p_idx   = ks_idx;
        p_key   = ks_key;
        step();
      end
      ks_ready = 1'b0;
      checkOutput("ks_transfers", 128'(ntr), 128'(11));
      checkOutput("ks_valid_drops", 128'(ks_valid), 128'(1'b0));
    end
`endif

    $display("[TB] restart from DONE with an ignored start mid-expansion");
    rd_idx = 4'd0;
    applyStimulus(fips_rk[0], 4, fips_rk[0]);
    rd_idx = 4'd1;
    step();
    checkOutput("ignored_start_rk1", rd_key, fips_rk[1]);
    rd_idx = 4'd10;
    step();
    checkOutput("ignored_start_rk10", rd_key, fips_rk[10]);

    $display("[TB] restart from DONE with an all-zero key");
    rd_idx = 4'd0;
    buildModel(128'h0);
    applyStimulus(128'h0, -1, fips_rk[0]);
    rd_idx = 4'd10;
    step();
    checkOutput("zero_key_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    rd_idx = 4'd1;
    step();
    checkOutput("zero_key_rk1", rd_key, 128'h62636363626363636263636362636363);

    $display("[TB] reset during expansion");
    rd_idx = 4'd10;
    start  = 1'b1;
    key_in = fips_rk[0];
    step();
    start = 1'b0;
    repeat (5) step();
    checkOutput("mid_busy_before_rst", 128'(busy), 128'(1'b1));
    checkOutput("mid_rd_old_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 128'(busy), 128'(1'b0));
    checkOutput("mid_rst_done", 128'(done), 128'(1'b0));
    checkOutput("mid_rst_kv", 128'(keys_valid), 128'(1'b0));
    checkOutput("mid_rst_rd_key", rd_key, 128'h0);
    checkOutput("mid_rst_rcon", 128'(dp_rcon), 128'h0);
    repeat (2) step();
    rst_n  = 1'b1;
    rd_idx = 4'd1;
    step();
    checkOutput("after_rst_rk1", rd_key, 128'h0);
    rd_idx = 4'd12;
    step();
    checkOutput("after_rst_idx12", rd_key, 128'h0);
    cnt_done = 0;
    cnt_busy = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    checkOutput("no_done_after_rst", 128'(cnt_done), 128'(0));
    checkOutput("no_busy_after_rst", 128'(cnt_busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
